// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and decode-side signal bundle for the instruction fetch queue.
interface inst_fetch_queue_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 32
);
    logic              flush;
    logic              fetch_valid;
    logic              fetch_inst2_valid;
    logic [DATA_W-1:0] fetch_pc;
    logic [DATA_W-1:0] fetch_inst1;
    logic [DATA_W-1:0] fetch_inst2;
    logic              fetch_pre_take1;
    logic              fetch_pre_take2;
    logic              fetch_ready;
    logic              deq_valid1;
    logic              deq_valid2;
    logic [DATA_W-1:0] deq_inst1;
    logic [DATA_W-1:0] deq_inst2;
    logic [DATA_W-1:0] deq_pc1;
    logic [DATA_W-1:0] deq_pc2;
    logic              deq_pre_take1;
    logic              deq_pre_take2;
    logic [1:0]        deq_take;
    logic [ADDR_W:0]   count;

    // Fetch unit / decode stage side
    modport master (
        output flush, fetch_valid, fetch_inst2_valid, fetch_pc,
               fetch_inst1, fetch_inst2, fetch_pre_take1, fetch_pre_take2,
               deq_take,
        input  fetch_ready, deq_valid1, deq_valid2, deq_inst1, deq_inst2,
               deq_pc1, deq_pc2, deq_pre_take1, deq_pre_take2, count
    );

    // Queue side
    modport slave (
        input  flush, fetch_valid, fetch_inst2_valid, fetch_pc,
               fetch_inst1, fetch_inst2, fetch_pre_take1, fetch_pre_take2,
               deq_take,
        output fetch_ready, deq_valid1, deq_valid2, deq_inst1, deq_inst2,
               deq_pc1, deq_pc2, deq_pre_take1, deq_pre_take2, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-width first-word-fall-through instruction fetch queue: up to two
// instructions in and two out per cycle, cleared by flush.
module inst_fetch_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_queue_if.slave   bus
);
    localparam int unsigned     CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    logic [DATA_W-1:0] r_inst [DEPTH];
    logic [DATA_W-1:0] r_pc   [DEPTH];
    logic [DEPTH-1:0]  r_take;
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_fetch_ready;
    logic              w_enq;
    logic [1:0]        w_enq_n;
    logic [1:0]        w_take_sat;
    logic [1:0]        w_deq_n;
    logic [DATA_W-1:0] w_pc_p4;
    logic [ADDR_W-1:0] w_head_p1;
    logic [ADDR_W-1:0] w_tail_p1;
    logic [ADDR_W-1:0] w_head_next;
    logic [ADDR_W-1:0] w_tail_next;
    logic [CNT_W-1:0]  w_count_next;

    // Ready only from registered occupancy: no path from deq_take
    assign w_fetch_ready = (r_count <= READY_MAX);
    assign w_enq         = bus.fetch_valid & w_fetch_ready & ~bus.flush;
    assign w_pc_p4       = bus.fetch_pc + DATA_W'(4);
    assign w_head_p1     = r_head + ADDR_W'(1);
    assign w_tail_p1     = r_tail + ADDR_W'(1);

    // Per-cycle enqueue and clamped dequeue amounts
    always_comb begin
        w_enq_n    = 2'd0;
        w_take_sat = bus.deq_take;
        w_deq_n    = 2'd0;
        if (w_enq) begin
            w_enq_n = bus.fetch_inst2_valid ? 2'd2 : 2'd1;
        end
        if (bus.deq_take == 2'd3) begin
            w_take_sat = 2'd2;
        end
        if (r_count >= CNT_W'(w_take_sat)) begin
            w_deq_n = w_take_sat;
        end else begin
            w_deq_n = r_count[1:0];
        end
    end

    // Next pointers and occupancy; flush overrides any enqueue/dequeue
    always_comb begin
        w_head_next  = r_head + ADDR_W'(w_deq_n);
        w_tail_next  = r_tail + ADDR_W'(w_enq_n);
        w_count_next = r_count + CNT_W'(w_enq_n) - CNT_W'(w_deq_n);
        if (bus.flush) begin
            w_head_next  = '0;
            w_tail_next  = '0;
            w_count_next = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
        end
    end

    // Entry storage; never cleared, validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_inst[r_tail] <= bus.fetch_inst1;
            r_pc[r_tail]   <= bus.fetch_pc;
            r_take[r_tail] <= bus.fetch_pre_take1;
            if (bus.fetch_inst2_valid) begin
                r_inst[w_tail_p1] <= bus.fetch_inst2;
                r_pc[w_tail_p1]   <= w_pc_p4;
                r_take[w_tail_p1] <= bus.fetch_pre_take2;
            end
        end
    end

    assign bus.fetch_ready   = w_fetch_ready;
    assign bus.deq_valid1    = (r_count != '0);
    assign bus.deq_valid2    = (r_count >= CNT_W'(2));
    assign bus.deq_inst1     = r_inst[r_head];
    assign bus.deq_inst2     = r_inst[w_head_p1];
    assign bus.deq_pc1       = r_pc[r_head];
    assign bus.deq_pc2       = r_pc[w_head_p1];
    assign bus.deq_pre_take1 = r_take[r_head];
    assign bus.deq_pre_take2 = r_take[w_head_p1];
    assign bus.count         = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_inst_fetch_queue;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        take;
    } ent_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    ent_t mq[$];

    inst_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        bus.flush             = 1'b0;
        bus.fetch_valid       = 1'b0;
        bus.fetch_inst2_valid = 1'b0;
        bus.fetch_pc          = '0;
        bus.fetch_inst1       = '0;
        bus.fetch_inst2       = '0;
        bus.fetch_pre_take1   = 1'b0;
        bus.fetch_pre_take2   = 1'b0;
        bus.deq_take          = 2'd0;
    endtask

    // Apply one cycle of stimulus, advance the reference model, sample #1 later
    task automatic do_cycle(input bit fv, input bit v2, input logic [31:0] pc,
                            input logic [31:0] i1, input logic [31:0] i2,
                            input bit t1, input bit t2, input logic [1:0] take,
                            input bit fl);
        int   sz;
        int   dn;
        bit   room;
        ent_t e;
        bus.fetch_valid       = fv;
        bus.fetch_inst2_valid = v2;
        bus.fetch_pc          = pc;
        bus.fetch_inst1       = i1;
        bus.fetch_inst2       = i2;
        bus.fetch_pre_take1   = t1;
        bus.fetch_pre_take2   = t2;
        bus.deq_take          = take;
        bus.flush             = fl;
        @(posedge clk);
        sz   = mq.size();
        room = (sz <= DEPTH - 2);
        if (fl) begin
            mq.delete();
        end else begin
            dn = (take == 2'd3) ? 2 : int'(take);
            if (dn > sz) dn = sz;
            for (int k = 0; k < dn; k++) void'(mq.pop_front());
            if (fv && room) begin
                e.inst = i1; e.pc = pc; e.take = t1;
                mq.push_back(e);
                if (v2) begin
                    e.inst = i2; e.pc = pc + 32'd4; e.take = t2;
                    mq.push_back(e);
                end
            end
        end
        #1;
        set_idle();
    endtask

    task automatic pair(input logic [31:0] pc, input logic [1:0] take);
        do_cycle(1'b1, 1'b1, pc, pc ^ 32'hA5A5_0000, (pc + 32'd4) ^ 32'hA5A5_0000,
                 1'b0, 1'b1, take, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        mq.delete();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors += 4;
        if (bus.count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        if (bus.deq_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid1: got %b expected 0", bus.deq_valid1); end
        if (bus.deq_valid2 !== 1'b0) begin miscompares++; $display("FAIL reset_valid2: got %b expected 0", bus.deq_valid2); end
        if (bus.fetch_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.fetch_ready); end
    endtask

    task automatic test_pair();
        apply_reset();
        do_cycle(1'b1, 1'b1, 32'h40, 32'h2001_0005, 32'h2002_0007, 1'b1, 1'b0, 2'd0, 1'b0);
        vectors += 9;
        if (bus.count !== 4'd2) begin miscompares++; $display("FAIL pair_count: got %0d expected 2", bus.count); end
        if (bus.deq_valid1 !== 1'b1) begin miscompares++; $display("FAIL pair_valid1: got %b expected 1", bus.deq_valid1); end
        if (bus.deq_valid2 !== 1'b1) begin miscompares++; $display("FAIL pair_valid2: got %b expected 1", bus.deq_valid2); end
        if (bus.deq_pc1 !== 32'h40) begin miscompares++; $display("FAIL pair_pc1: got %h expected 00000040", bus.deq_pc1); end
        if (bus.deq_pc2 !== 32'h44) begin miscompares++; $display("FAIL pair_pc2: got %h expected 00000044", bus.deq_pc2); end
        if (bus.deq_inst1 !== 32'h2001_0005) begin miscompares++; $display("FAIL pair_inst1: got %h expected 20010005", bus.deq_inst1); end
        if (bus.deq_inst2 !== 32'h2002_0007) begin miscompares++; $display("FAIL pair_inst2: got %h expected 20020007", bus.deq_inst2); end
        if (bus.deq_pre_take1 !== 1'b1 || bus.deq_pre_take2 !== 1'b0) begin
            miscompares++; $display("FAIL pair_take: got %b%b expected 10", bus.deq_pre_take1, bus.deq_pre_take2);
        end
        if (bus.fetch_ready !== 1'b1) begin miscompares++; $display("FAIL pair_ready: got %b expected 1", bus.fetch_ready); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int p = 0; p < 3; p++) pair(32'h1000 + 32'(8 * p), 2'd0);
        vectors += 2;
        if (bus.count !== 4'd6) begin miscompares++; $display("FAIL fill6_count: got %0d expected 6", bus.count); end
        if (bus.fetch_ready !== 1'b1) begin miscompares++; $display("FAIL fill6_ready: got %b expected 1", bus.fetch_ready); end
        pair(32'h1018, 2'd0);
        vectors += 2;
        if (bus.count !== 4'd8) begin miscompares++; $display("FAIL fill8_count: got %0d expected 8", bus.count); end
        if (bus.fetch_ready !== 1'b0) begin miscompares++; $display("FAIL fill8_ready: got %b expected 0", bus.fetch_ready); end
        pair(32'h2000, 2'd0);
        vectors += 2;
        if (bus.count !== 4'd8) begin miscompares++; $display("FAIL fill_drop_count: got %0d expected 8", bus.count); end
        if (bus.deq_pc1 !== 32'h1000) begin miscompares++; $display("FAIL fill_drop_head: got %h expected 00001000", bus.deq_pc1); end
        // Drain fully to confirm the dropped group never entered
        for (int p = 0; p < 4; p++) begin
            vectors++;
            if (bus.deq_pc1 !== 32'h1000 + 32'(8 * p)) begin
                miscompares++; $display("FAIL fill_drain_pc1: got %h expected %h", bus.deq_pc1, 32'h1000 + 32'(8 * p));
            end
            do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 2'd2, 1'b0);
        end
        vectors++;
        if (bus.count !== 4'd0) begin miscompares++; $display("FAIL fill_drain_count: got %0d expected 0", bus.count); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        pair(32'h0, 2'd0);
        for (int k = 0; k < 20; k++) begin
            vectors += 3;
            if (bus.count !== 4'd2) begin miscompares++; $display("FAIL b2b_count: cycle %0d got %0d expected 2", k, bus.count); end
            if (bus.deq_pc1 !== 32'(8 * k)) begin miscompares++; $display("FAIL b2b_pc1: cycle %0d got %h expected %h", k, bus.deq_pc1, 32'(8 * k)); end
            if (bus.deq_pc2 !== 32'(8 * k + 4)) begin miscompares++; $display("FAIL b2b_pc2: cycle %0d got %h expected %h", k, bus.deq_pc2, 32'(8 * k + 4)); end
            pair(32'(8 * (k + 1)), 2'd2);
        end
    endtask

    task automatic test_single();
        apply_reset();
        do_cycle(1'b1, 1'b0, 32'h100, 32'hAAAA_0100, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'd0, 1'b0);
        vectors += 2;
        if (bus.count !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", bus.count); end
        if (bus.deq_valid2 !== 1'b0) begin miscompares++; $display("FAIL single_valid2: got %b expected 0", bus.deq_valid2); end
        pair(32'h104, 2'd0);
        vectors += 4;
        if (bus.count !== 4'd3) begin miscompares++; $display("FAIL single_pair_count: got %0d expected 3", bus.count); end
        if (bus.deq_pc1 !== 32'h100) begin miscompares++; $display("FAIL single_pc1: got %h expected 00000100", bus.deq_pc1); end
        if (bus.deq_pc2 !== 32'h104) begin miscompares++; $display("FAIL single_pc2: got %h expected 00000104", bus.deq_pc2); end
        if (bus.deq_inst1 !== 32'hAAAA_0100) begin miscompares++; $display("FAIL single_inst1: got %h expected aaaa0100", bus.deq_inst1); end
        do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 2'd1, 1'b0);
        vectors += 3;
        if (bus.count !== 4'd2) begin miscompares++; $display("FAIL take1_count: got %0d expected 2", bus.count); end
        if (bus.deq_pc1 !== 32'h104) begin miscompares++; $display("FAIL take1_pc1: got %h expected 00000104", bus.deq_pc1); end
        if (bus.deq_pc2 !== 32'h108) begin miscompares++; $display("FAIL take1_pc2: got %h expected 00000108", bus.deq_pc2); end
    endtask

    task automatic test_flush();
        apply_reset();
        pair(32'h200, 2'd0);
        pair(32'h208, 2'd0);
        do_cycle(1'b1, 1'b0, 32'h210, 32'h1, 32'h2, 1'b0, 1'b0, 2'd0, 1'b0);
        vectors++;
        if (bus.count !== 4'd5) begin miscompares++; $display("FAIL flush_pre_count: got %0d expected 5", bus.count); end
        do_cycle(1'b1, 1'b1, 32'h300, 32'h3, 32'h4, 1'b0, 1'b0, 2'd2, 1'b1);
        vectors += 4;
        if (bus.count !== 4'd0) begin miscompares++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
        if (bus.deq_valid1 !== 1'b0) begin miscompares++; $display("FAIL flush_valid1: got %b expected 0", bus.deq_valid1); end
        if (bus.deq_valid2 !== 1'b0) begin miscompares++; $display("FAIL flush_valid2: got %b expected 0", bus.deq_valid2); end
        if (bus.fetch_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b expected 1", bus.fetch_ready); end
        pair(32'h400, 2'd0);
        vectors += 2;
        if (bus.count !== 4'd2) begin miscompares++; $display("FAIL post_flush_count: got %0d expected 2", bus.count); end
        if (bus.deq_pc1 !== 32'h400) begin miscompares++; $display("FAIL post_flush_pc1: got %h expected 00000400", bus.deq_pc1); end
    endtask

    task automatic test_clamp();
        apply_reset();
        pair(32'h500, 2'd0);
        do_cycle(1'b1, 1'b0, 32'h508, 32'h5, 32'h6, 1'b0, 1'b0, 2'd2, 1'b0);
        vectors += 2;
        if (bus.count !== 4'd1) begin miscompares++; $display("FAIL clamp_pre_count: got %0d expected 1", bus.count); end
        if (bus.deq_pc1 !== 32'h508) begin miscompares++; $display("FAIL clamp_pre_pc1: got %h expected 00000508", bus.deq_pc1); end
        do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 2'd2, 1'b0);
        vectors += 2;
        if (bus.count !== 4'd0) begin miscompares++; $display("FAIL clamp_count: got %0d expected 0", bus.count); end
        if (bus.deq_valid1 !== 1'b0) begin miscompares++; $display("FAIL clamp_valid1: got %b expected 0", bus.deq_valid1); end
        pair(32'h600, 2'd2);
        vectors += 3;
        if (bus.count !== 4'd2) begin miscompares++; $display("FAIL empty_take_count: got %0d expected 2", bus.count); end
        if (bus.deq_pc1 !== 32'h600) begin miscompares++; $display("FAIL empty_take_pc1: got %h expected 00000600", bus.deq_pc1); end
        if (bus.deq_pc2 !== 32'h604) begin miscompares++; $display("FAIL empty_take_pc2: got %h expected 00000604", bus.deq_pc2); end
    endtask

    task automatic test_random();
        int          sz;
        logic [31:0] pc;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            sz = mq.size();
            vectors += 4;
            if (bus.count !== 4'(sz)) begin miscompares++; $display("FAIL rnd_count: cycle %0d got %0d expected %0d", k, bus.count, sz); end
            if (bus.fetch_ready !== (sz <= DEPTH - 2)) begin miscompares++; $display("FAIL rnd_ready: cycle %0d got %b size %0d", k, bus.fetch_ready, sz); end
            if (bus.deq_valid1 !== (sz >= 1)) begin miscompares++; $display("FAIL rnd_valid1: cycle %0d got %b size %0d", k, bus.deq_valid1, sz); end
            if (bus.deq_valid2 !== (sz >= 2)) begin miscompares++; $display("FAIL rnd_valid2: cycle %0d got %b size %0d", k, bus.deq_valid2, sz); end
            if (sz >= 1) begin
                vectors++;
                if (bus.deq_pc1 !== mq[0].pc || bus.deq_inst1 !== mq[0].inst || bus.deq_pre_take1 !== mq[0].take) begin
                    miscompares++;
                    $display("FAIL rnd_head: cycle %0d got pc %h inst %h t %b expected pc %h inst %h t %b",
                             k, bus.deq_pc1, bus.deq_inst1, bus.deq_pre_take1, mq[0].pc, mq[0].inst, mq[0].take);
                end
            end
            if (sz >= 2) begin
                vectors++;
                if (bus.deq_pc2 !== mq[1].pc || bus.deq_inst2 !== mq[1].inst || bus.deq_pre_take2 !== mq[1].take) begin
                    miscompares++;
                    $display("FAIL rnd_next: cycle %0d got pc %h inst %h t %b expected pc %h inst %h t %b",
                             k, bus.deq_pc2, bus.deq_inst2, bus.deq_pre_take2, mq[1].pc, mq[1].inst, mq[1].take);
                end
            end
            pc = $urandom();
            if (k % 97 == 5) pc = 32'hFFFF_FFFC;
            do_cycle(($urandom_range(0, 3) != 0), 1'($urandom()), {pc[31:2], 2'b00},
                     $urandom(), $urandom(), 1'($urandom()), 1'($urandom()),
                     2'($urandom_range(0, 3)), ($urandom_range(0, 40) == 0));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        set_idle();
        test_reset();
        test_pair();
        test_fill();
        test_back_to_back();
        test_single();
        test_flush();
        test_clamp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-width instruction fetch queue between the instruction-memory interface and the decode/rename stage of the 2-way superscalar core.
- Accepts a fetch group of up to two instructions per cycle, each with its PC and branch-prediction bit.
- Presents the two oldest instructions to decode in first-word-fall-through order.
- Decouples fetch stalls from decode stalls and is cleared on branch-misprediction flush.

Parameters:
DEPTH, 8, number of instruction entries; power of two, at least 4
ADDR_W, 3, log2(DEPTH)
DATA_W, 32, instruction and PC width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
flush  input  1  misprediction/redirect; empties queue
fetch_valid  input  1  fetch group present (InstMem_Ready & InstMem_Read)
fetch_inst2_valid  input  1  second instruction of the group is valid
fetch_pc  input  32  PC of first instruction of the group
fetch_inst1  input  32  first instruction word
fetch_inst2  input  32  second instruction word
fetch_pre_take1  input  1  predicted-taken bit for inst1
fetch_pre_take2  input  1  predicted-taken bit for inst2
fetch_ready  output  1  queue can accept a full two-instruction group this cycle
deq_valid1  output  1  head entry valid
deq_valid2  output  1  head+1 entry valid
deq_inst1, deq_inst2  output  32 each  head and head+1 instruction words
deq_pc1, deq_pc2  output  32 each  head and head+1 PCs
deq_pre_take1, deq_pre_take2  output  1 each  head and head+1 prediction bits
deq_take  input  2  number of instructions decode consumes this cycle (0, 1 or 2)
count  output  ADDR_W+1  current occupancy

Behaviour:
- Circular buffer with head pointer, tail pointer (ADDR_W bits, wrap modulo DEPTH) and count (0..DEPTH).
- Reset (rst=1 at a clk edge): head=0, tail=0, count=0. The following then hold: deq_valid1=0, deq_valid2=0, fetch_ready=1. Entry storage is not cleared. deq_* data outputs are don't-care while their valid is 0.
- fetch_ready = (count <= DEPTH-2). It is computed from the registered count only, never from the same-cycle deq_take, so there is no combinational path from deq_take to fetch_ready.
- Enqueue occurs when fetch_valid & fetch_ready & ~flush:
  - Entry[tail] gets {fetch_inst1, fetch_pc, fetch_pre_take1}.
  - If fetch_inst2_valid=1, entry[tail+1] gets {fetch_inst2, fetch_pc+4, fetch_pre_take2}.
  - tail advances by 1 or 2.
  - fetch_pc+4 is a 32-bit add; carry out is discarded.
- Enqueue attempts with fetch_ready=0 are dropped; fetch must hold and retry.
- Dequeue outputs are combinational from the registers (first-word fall-through, zero latency):
  - deq_valid1 = (count >= 1); deq_valid2 = (count >= 2).
  - Output fields read entry[head] and entry[head+1 mod DEPTH].
- The effective dequeue count is min(deq_take, count), clamped. deq_take=3 is treated as 2. head advances by the effective count.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq_n - deq_n, with enq_n and deq_n each in {0,1,2}. Same-cycle enqueued entries are not visible at the outputs until the next cycle, even when the queue was empty.
- flush=1 (rst=0): head=tail=0, count=0 at the edge. Enqueue and dequeue in that cycle are ignored. deq_valid* drop to 0 the next cycle.
- Priority: rst > flush > normal operation. rst or flush asserted mid-stream discards all entries with no partial drain.
- Full: count=DEPTH-1 or DEPTH gives fetch_ready=0. Because enqueue is gated by fetch_ready, count never exceeds DEPTH.
- Empty: count=0 gives both deq_valid* = 0, and any deq_take is ignored.
- Order is strict program order; no entry is dropped or reordered except by flush or reset.

Test Plan:
1. Reset, then fetch_valid=1, fetch_pc=0x0000_0040, inst1=0x2001_0005, inst2=0x2002_0007, inst2_valid=1, deq_take=0 -> next cycle count=2, deq_valid1=deq_valid2=1, deq_pc1=0x40, deq_pc2=0x44, fetch_ready=1.
2. Fill with deq_take=0 and DEPTH=8 -> after 3 pairs, count=6 and fetch_ready=1; after the 4th pair, count=8 and fetch_ready=0; a 5th group presented is not stored and count stays 8.
3. Steady state with two in and two out every cycle for 20 cycles starting at PC 0 -> deq_pc1 sequence 0,8,16,…; count constant at 2; pointers wrap past 7 with no gap or duplicate.
4. Single-instruction group (inst2_valid=0, pc=0x100), then pair at pc=0x104 -> entries in order 0x100,0x104,0x108; a deq_take=1 cycle leaves deq_pc1=0x104.
5. count=5, flush=1 together with fetch_valid=1 and deq_take=2 -> next cycle count=0, deq_valid1=0, fetch_ready=1; the group presented in the flush cycle is absent.
6. count=1, deq_take=2 -> clamped: count=0 and head advances by 1. count=0, deq_take=2, fetch_valid=1 pair -> count=2 and outputs show the new pair the next cycle.
